// File: rtl/top_all_lms.sv
`default_nettype none
// ============================================================================
// Module  : top_all_lms
// Brief   : 32-tap LMS adaptive FIR behind an oversampled SPI-slave port.
// Revision: 1.0  initial release
// ============================================================================
module top_all_lms #(
    parameter int              TAPS     = 32,
    parameter int              DW       = 14,
    parameter int              WW       = 20,
    parameter int              WF       = 16,
    parameter int              MU_SHIFT = 12,
    parameter logic [DW-1:0]   HDR      = 14'h0FFF
) (
    input  logic clk,
    input  logic rstn,
    input  logic sck,
    input  logic mosi,
    input  logic cs,
    output logic miso
);

    localparam int IW = $clog2(TAPS);
    localparam int PW = WW + DW;
    localparam int AW = PW + IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GOT_HDR = 2'd1;
    localparam logic [1:0] ST_GOT_X   = 2'd2;
    localparam logic [1:0] ST_COMPUTE = 2'd3;

    localparam logic [1:0] PH_SHIFT = 2'd0;
    localparam logic [1:0] PH_MAC   = 2'd1;
    localparam logic [1:0] PH_ERR   = 2'd2;
    localparam logic [1:0] PH_UPD   = 2'd3;

    logic r_sck_meta, r_sck_s, r_sck_q;
    logic r_cs_meta, r_cs_s, r_cs_q;
    logic r_mosi_meta, r_mosi_s;
    logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

    logic [DW-1:0] r_rx;
    logic [3:0]    r_cnt;
    logic          w_word_ok, w_word_bad;
    logic [DW-1:0] r_tx;
    logic          r_miso;

    logic [1:0]           r_state, r_phase;
    logic [IW-1:0]        r_idx;
    logic signed [DW-1:0] r_x, r_d, r_e, r_result;
    logic signed [AW-1:0] r_acc;
    logic signed [DW-1:0] r_xd [TAPS];
    logic signed [WW-1:0] r_w  [TAPS];

    logic signed [WW-1:0] w_wsel, w_mul_a;
    logic signed [DW-1:0] w_xsel;
    logic signed [PW-1:0] w_a_ext, w_b_ext, w_prod, w_prod_sh;
    logic signed [AW-1:0] w_acc_next, w_acc_sh;
    logic [DW-1:0]        w_y, w_e;
    logic [DW:0]          w_diff;
    logic [PW:0]          w_wsum;
    logic [WW-1:0]        w_wnew;
    logic                 w_y_ovf, w_w_ovf;

    // Two-stage synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_sck_meta  <= 1'b0;
            r_sck_s     <= 1'b0;
            r_sck_q     <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_s      <= 1'b1;
            r_cs_q      <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_s    <= 1'b0;
        end else begin
            r_sck_meta  <= sck;
            r_sck_s     <= r_sck_meta;
            r_sck_q     <= r_sck_s;
            r_cs_meta   <= cs;
            r_cs_s      <= r_cs_meta;
            r_cs_q      <= r_cs_s;
            r_mosi_meta <= mosi;
            r_mosi_s    <= r_mosi_meta;
        end
    end

    assign w_sck_rise = r_sck_s & ~r_sck_q;
    assign w_sck_fall = ~r_sck_s & r_sck_q;
    assign w_cs_rise  = r_cs_s & ~r_cs_q;
    assign w_cs_fall  = ~r_cs_s & r_cs_q;

    assign w_word_ok  = w_cs_rise && (r_cnt == 4'd14);
    assign w_word_bad = w_cs_rise && (r_cnt != 4'd14);

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_rx  <= '0;
            r_cnt <= '0;
        end else if (w_cs_fall) begin
            r_cnt <= '0;
        end else if (w_sck_rise && !r_cs_s) begin
            r_rx <= {r_rx[DW-2:0], r_mosi_s};
            if (r_cnt != 4'd15)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_tx   <= '0;
            r_miso <= 1'b0;
        end else if (w_cs_fall) begin
            r_tx   <= r_result;
            r_miso <= r_result[DW-1];
        end else if (r_cs_s) begin
            r_miso <= 1'b0;
        end else if (w_sck_fall) begin
            r_tx   <= {r_tx[DW-2:0], 1'b0};
            r_miso <= r_tx[DW-2];
        end
    end

    assign miso = r_miso;

    // One shared multiplier: w*x during the MAC pass, e*x during the update pass
    assign w_wsel     = r_w[r_idx];
    assign w_xsel     = r_xd[r_idx];
    assign w_mul_a    = (r_phase == PH_MAC) ? w_wsel : {{(WW-DW){r_e[DW-1]}}, r_e};
    assign w_a_ext    = {{DW{w_mul_a[WW-1]}}, w_mul_a};
    assign w_b_ext    = {{WW{w_xsel[DW-1]}}, w_xsel};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_sh  = w_prod >>> MU_SHIFT;
    assign w_acc_next = r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};

    assign w_acc_sh = r_acc >>> WF;
    assign w_y_ovf  = ~(&w_acc_sh[AW-1:DW-1]) & (|w_acc_sh[AW-1:DW-1]);
    assign w_y      = w_y_ovf ? {w_acc_sh[AW-1], {(DW-1){~w_acc_sh[AW-1]}}}
                              : w_acc_sh[DW-1:0];

    assign w_diff = {r_d[DW-1], r_d} - {w_y[DW-1], w_y};
    assign w_e    = (w_diff[DW] ^ w_diff[DW-1]) ? {w_diff[DW], {(DW-1){~w_diff[DW]}}}
                                                : w_diff[DW-1:0];

    assign w_wsum  = {{(PW+1-WW){w_wsel[WW-1]}}, w_wsel} + {w_prod_sh[PW-1], w_prod_sh};
    assign w_w_ovf = ~(&w_wsum[PW:WW-1]) & (|w_wsum[PW:WW-1]);
    assign w_wnew  = w_w_ovf ? {w_wsum[PW], {(WW-1){~w_wsum[PW]}}} : w_wsum[WW-1:0];

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state  <= ST_IDLE;
            r_phase  <= PH_SHIFT;
            r_idx    <= '0;
            r_acc    <= '0;
            r_x      <= '0;
            r_d      <= '0;
            r_e      <= '0;
            r_result <= '0;
            for (int k = 0; k < TAPS; k++) begin
                r_xd[k] <= '0;
                r_w[k]  <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_word_ok && (r_rx == HDR))
                        r_state <= ST_GOT_HDR;
                end
                ST_GOT_HDR: begin
                    if (w_word_ok) begin
                        r_x     <= r_rx;
                        r_state <= ST_GOT_X;
                    end else if (w_word_bad) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GOT_X: begin
                    if (w_word_ok) begin
                        r_d     <= r_rx;
                        r_phase <= PH_SHIFT;
                        r_state <= ST_COMPUTE;
                    end else if (w_word_bad) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COMPUTE: begin
                    case (r_phase)
                        PH_SHIFT: begin
                            for (int k = TAPS - 1; k > 0; k--)
                                r_xd[k] <= r_xd[k-1];
                            r_xd[0] <= r_x;
                            r_acc   <= '0;
                            r_idx   <= '0;
                            r_phase <= PH_MAC;
                        end
                        PH_MAC: begin
                            r_acc <= w_acc_next;
                            if (r_idx == LAST_IDX) begin
                                r_phase <= PH_ERR;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                        PH_ERR: begin
                            r_e     <= w_e;
                            r_idx   <= '0;
                            r_phase <= PH_UPD;
                        end
                        default: begin
                            r_w[r_idx] <= w_wnew;
                            if (r_idx == LAST_IDX) begin
                                r_result <= r_e;
                                r_phase  <= PH_SHIFT;
                                r_state  <= ST_IDLE;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_top_all_lms.sv
`default_nettype none
// Directed bench for top_all_lms: SPI frames driven from the host side,
// error words read back on miso and checked against hand values and a reference model.
module tb_top_all_lms;

    localparam logic [13:0] HDR = 14'h0FFF;

    logic clk = 1'b0;
    logic rstn, sck, mosi, cs;
    logic miso;

    int n_checks = 0;
    int n_pass   = 0;

    longint m_xd [32];
    longint m_w  [32];
    longint m_e;

    logic [13:0] rd;

    top_all_lms dut (
        .clk  (clk),
        .rstn (rstn),
        .sck  (sck),
        .mosi (mosi),
        .cs   (cs),
        .miso (miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    function automatic longint sat(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_xd[k] = 0;
            m_w[k]  = 0;
        end
        m_e = 0;
    endtask

    task automatic model_pair(input int x, input int d);
        longint acc, y;
        for (int k = 31; k > 0; k--) m_xd[k] = m_xd[k-1];
        m_xd[0] = x;
        acc = 0;
        for (int k = 0; k < 32; k++) acc += m_w[k] * m_xd[k];
        y   = sat(acc >>> 16, -8192, 8191);
        m_e = sat(longint'(d) - y, -8192, 8191);
        for (int k = 0; k < 32; k++)
            m_w[k] = sat(m_w[k] + ((m_e * m_xd[k]) >>> 12), -524288, 524287);
    endtask

    // One SPI frame: nbits clocks, MSB first; miso captured just before each rising sck
    task automatic xfer(input logic [13:0] w, input int nbits, input int gap,
                        output logic [13:0] r);
        r = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[nbits-1-i];
            repeat (5) @(negedge clk);
            r   = {r[12:0], miso};
            sck = 1'b1;
            repeat (10) @(negedge clk);
            sck = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        cs = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pair(input int x, input int d);
        logic [13:0] r;
        xfer(HDR, 14, 100, r);
        xfer(14'(x), 14, 100, r);
        xfer(14'(d), 14, 100, r);
        model_pair(x, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
    endtask

    initial begin
        rstn = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        cs   = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        repeat (5) @(negedge clk);

        check("reset_miso", {13'd0, miso}, 14'd0);
        xfer(14'h0000, 14, 100, rd);
        check("reset_result", rd, 14'h0000);

        send_pair(1355, 1356);
        xfer(14'h0000, 14, 100, rd);
        check("pair1_e", rd, 14'h054C);

        send_pair(1365, 1366);
        xfer(14'h0000, 14, 100, rd);
        check("pair2_e", rd, 14'h054D);

        // Short x frame must drop back to IDLE so the next two words are ignored
        xfer(HDR, 14, 100, rd);
        xfer(14'h0155, 10, 100, rd);
        xfer(14'd100, 14, 100, rd);
        xfer(14'd200, 14, 100, rd);
        xfer(14'h0000, 14, 100, rd);
        check("short_dropped", rd, 14'h054D);

        send_pair(100, 200);
        xfer(14'h0000, 14, 100, rd);
        check("after_short_e", rd, 14'd190);

        xfer(14'h0123, 14, 100, rd);
        xfer(14'h0050, 14, 100, rd);
        xfer(14'h0060, 14, 100, rd);
        xfer(14'h0000, 14, 100, rd);
        check("hunt_ignored", rd, 14'd190);

        send_pair(8191, -8192);
        xfer(14'h0000, 14, 100, rd);
        check("sat_first_e", rd, 14'h2000);
        check("idle_miso", {13'd0, miso}, 14'd0);
        for (int i = 0; i < 10; i++) begin
            send_pair(8191, -8192);
            xfer(14'h0000, 14, 100, rd);
            check("sat_train_e", rd, 14'(m_e));
        end
        for (int i = 0; i < 3; i++) begin
            send_pair(-8192, -8192);
            xfer(14'h0000, 14, 100, rd);
            check("sat_flip_e", rd, 14'(m_e));
        end

        // Reset while the datapath is busy with a pair
        xfer(HDR, 14, 100, rd);
        xfer(14'd1355, 14, 100, rd);
        xfer(14'd1356, 14, 0, rd);
        repeat (12) @(negedge clk);
        do_reset();
        check("midreset_miso", {13'd0, miso}, 14'd0);
        repeat (100) @(negedge clk);
        xfer(14'h0000, 14, 100, rd);
        check("midreset_result", rd, 14'h0000);

        send_pair(1355, 1356);
        xfer(14'h0000, 14, 100, rd);
        check("midreset_pair1", rd, 14'h054C);
        send_pair(1365, 1366);
        xfer(14'h0000, 14, 100, rd);
        check("midreset_pair2", rd, 14'h054D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/top_all_lms.md
# top_all_lms

`top_all_lms` is a 32-tap LMS adaptive FIR filter with an SPI-slave front end. It is the chip-level block of the adaptive-filter design. An external host sends a sample pair (input x, desired d) over SPI as three 14-bit frames. The block then filters x, computes the error e = d − y, updates its weights, and returns e on `miso` during the following frames.

## Interface
Parameters:
- `TAPS`, 32: number of filter taps.
- `DW`, 14: sample and SPI word width, two's complement.
- `WW`, 20: weight width, signed, with `WF` fractional bits.
- `WF`, 16: number of fractional bits in each weight.
- `MU_SHIFT`, 12: step size mu = 2^-`MU_SHIFT`, applied to raw integer products.
- `HDR`, 14'h0FFF: header word that marks the start of a sample pair.

Ports:
- `clk`  in  1  system clock. The SPI is oversampled; sck period ≥ 20 clk.
- `rstn`  in  1  synchronous, active-high reset, despite the name.
- `sck`  in  1  SPI clock, asynchronous, idle low.
- `mosi`  in  1  SPI data in, asynchronous.
- `cs`  in  1  chip select, active low, asynchronous.
- `miso`  out  1  SPI data out.

## Operation
- `sck`, `mosi` and `cs` each pass through a 2-FF synchronizer into `clk`. Edges of `sck` and `cs` are detected in the `clk` domain.
- Frame format:
  - A frame is cs low, then N sck rising edges, then cs high.
  - mosi is sampled on each sck rising edge, MSB first, into a 14-bit shift register.
  - The bit counter saturates at 15.
  - On cs rising: if count == 14 the word is valid; otherwise it is discarded and the protocol FSM returns to IDLE.
- Protocol FSM states: IDLE, GOT_HDR, GOT_X, COMPUTE.
  - IDLE: a valid word equal to `HDR` moves to GOT_HDR. Any other word is ignored.
  - GOT_HDR: a valid word is latched as x and moves to GOT_X.
  - GOT_X: a valid word is latched as d and moves to COMPUTE.
  - COMPUTE: when the datapath finishes, the FSM returns to IDLE. Frames that end during COMPUTE are dropped.
- Datapath (sequential, single multiplier allowed):
  1. Shift the delay line: xd[k] ← xd[k−1] for k = 31..1, then xd[0] ← x.
  2. acc = Σ w[k]·xd[k] over k = 0..31. acc is 39-bit signed.
  3. y = sat14(acc >>> WF), using an arithmetic shift.
  4. e = sat14(d − y), computed at 15 bits.
  5. For each k: w[k] ← satWW(w[k] + ((e·xd[k]) >>> MU_SHIFT)).
  6. Result register ← e.
- sat14 clamps to the range −8192..8191. satWW clamps to the range of `WW`-bit signed values.
- MISO behaviour:
  - On a cs falling edge, the tx shift register loads the result register and miso drives its MSB.
  - On each sck falling edge the tx register shifts left and miso drives the next bit.
  - While cs is high, miso = 0.
- Reset (`rstn` = 1 at a clk edge) clears:
  - all weights, delay line, x, d and the result register,
  - the rx and tx shift registers and the bit counter,
  - `miso`, which resets to 0,
  - the FSM, which resets to IDLE.

  Reset takes effect mid-frame or mid-COMPUTE and abandons any operation in progress.

## Timing
- Synchronizer latency is 2 clk plus 1 clk for edge detection.
- mosi must be stable around each sck rising edge for at least 3 clk.
- COMPUTE latency:
  - starts ≤ 4 clk after the synchronized cs rising edge of the d frame,
  - takes ≤ 2·TAPS + 8 = 72 clk,
  - the result register is valid at the end of COMPUTE.
- The host must leave ≥ 80 clk between the end of the d frame and the next cs falling edge, so that e is ready for readout.
- The miso bit for the frame is valid ≤ 4 clk after each synchronized cs falling or sck falling edge.

## Test plan
- Reset then one pair: HDR, x=1355, d=1356.
  - y = 0, so e = 1356.
  - The next frame reads back 0x054C on miso.
  - w[0] = (1356·1355)>>>12 = 448. All other weights stay 0.
- Second pair: x=1365, d=1366.
  - acc = 448·1365 = 611520, so y = 9 and e = 1357.
  - The next readout is 0x054D.
- Short frame: a 10-bit frame after HDR is discarded.
  - The FSM returns to IDLE and x is unchanged.
  - A following full triple is processed normally.
- Header hunting:
  - Sending 0x0123 in IDLE is ignored.
  - A non-HDR word sent while expecting a header does not start a pair.
- Saturation: preload large weights by running many pairs with x = 8191, d = −8192.
  - e stays within −8192..8191.
  - Weights clamp and do not wrap.
- Reset mid-COMPUTE: assert `rstn` during computation.
  - Afterwards all state is zero and `miso` = 0.
  - The next pair behaves exactly like the first scenario.
